// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo
//   Multi-cycle MIPS control unit. A state register steps each instruction
//   through fetch, decode, execute, memory and write-back. Memory states can
//   stall on mem_ready, and undecoded opcodes raise a one-cycle illegal flag.
//
// Ports
//   clk, rst_n        : rising-edge clock, synchronous active-low reset
//   Op[5:0]           : opcode, sampled only in DECODE
//   mem_ready         : memory finished the current access this cycle
//   pcwrite .. alusrca: single-bit datapath controls
//   alusrcb[1:0]      : ALU B select (reg, 4, sext imm, imm<<2)
//   aluop[ALUOP_W-1:0]: ALU function code
//   pcsrc[1:0]        : next-PC select (ALU, ALUOut, jump target)
//   illegal           : one-cycle pulse on an undecoded opcode
//   instr_done        : one-cycle pulse in the last state of an instruction
//   state[3:0]        : current state code, for debug
module unidad_control_multiciclo #(
  parameter int ALUOP_W     = 3,
  parameter bit ENABLE_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         pcsrc,
  output logic               illegal,
  output logic               instr_done,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       rdy;

  // With wait-states disabled every memory access completes in one cycle.
  assign rdy = ENABLE_WAIT ? mem_ready : 1'b1;

  // State and latched opcode registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= Op;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = S_FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = '0;
    pcsrc       = 2'b00;
    illegal     = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        aluop   = ALUOP_W'(3'b001);
        irwrite = rdy;
        pcwrite = rdy;
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALUOP_W'(3'b001);
        case (Op)
          OP_RTYPE:                         state_d = S_EXECR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXECI;
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_W'(3'b001);
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        state_d = rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        // The write strobe is held off until memory accepts it, so a store
        // produces exactly one memwrite cycle regardless of wait-states.
        iord       = 1'b1;
        memwrite   = rdy;
        instr_done = rdy;
        state_d    = rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALUOP_W'(3'b111);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op_q)
          OP_ADDI: aluop = ALUOP_W'(3'b101);
          OP_SLTI: aluop = ALUOP_W'(3'b100);
          OP_ANDI: aluop = ALUOP_W'(3'b011);
          OP_ORI:  aluop = ALUOP_W'(3'b010);
          default: aluop = '0;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        regdst     = (op_q == OP_RTYPE);
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        alusrcb     = 2'b00;
        aluop       = ALUOP_W'(3'b000);
        pcwritecond = 1'b1;
        pcsrc       = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsrc      = 2'b10;
        instr_done = 1'b1;
      end
      default: begin
        // Unreachable codes recover to FETCH and report themselves.
        illegal = 1'b1;
        state_d = S_FETCH;
      end
    endcase

    // Reset blanks every control combinationally, so an abandoned
    // instruction cannot emit a write strobe in the reset cycle.
    if (!rst_n) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      aluop       = '0;
      pcsrc       = 2'b00;
      illegal     = 1'b0;
      instr_done  = 1'b0;
    end
  end

  assign state = rst_n ? state_q : 4'd0;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo. Instance u_dut uses the
// default wait-state behaviour; u_nw has ENABLE_WAIT=0 and a 4-bit aluop.
module tb_unidad_control_multiciclo;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic       mem_ready;

  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal, instr_done;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  logic       n_pcwrite, n_pcwritecond, n_iord, n_memread, n_memwrite, n_irwrite;
  logic       n_memtoreg, n_regdst, n_regwrite, n_alusrca, n_illegal, n_instr_done;
  logic [1:0] n_alusrcb, n_pcsrc;
  logic [3:0] n_aluop;
  logic [3:0] n_state;

  int vectors;
  int miscompares;

  unidad_control_multiciclo u_dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  unidad_control_multiciclo #(.ALUOP_W(4), .ENABLE_WAIT(1'b0)) u_nw (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .pcwrite(n_pcwrite), .pcwritecond(n_pcwritecond), .iord(n_iord),
    .memread(n_memread), .memwrite(n_memwrite), .irwrite(n_irwrite),
    .memtoreg(n_memtoreg), .regdst(n_regdst), .regwrite(n_regwrite),
    .alusrca(n_alusrca), .alusrcb(n_alusrcb), .aluop(n_aluop), .pcsrc(n_pcsrc),
    .illegal(n_illegal), .instr_done(n_instr_done), .state(n_state)
  );

  // All controls of u_dut packed, used for the all-zero reset checks.
  logic [22:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
                illegal, instr_done, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle one time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    Op          = 6'b000000;
    mem_ready   = 1'b1;

    // Reset
    tick();
    tick();
    chk("rst_ctl_zero", 32'(ctl), 32'd0);
    chk("rst_nw_state", 32'(n_state), 32'd0);

    // R-type: 0,1,6,8,0
    rst_n = 1'b1; #1;
    chk("r_s0_state", 32'(state), 32'd0);
    chk("r_s0_memread", 32'(memread), 32'd1);
    chk("r_s0_pc_ir", 32'({pcwrite, irwrite}), 32'b11);
    chk("r_s0_alu", 32'({alusrcb, aluop}), 32'b01_001);
    chk("r_s0_done", 32'(instr_done), 32'd0);
    tick();
    chk("r_s1_state", 32'(state), 32'd1);
    chk("r_s1_alu", 32'({alusrcb, aluop}), 32'b11_001);
    chk("r_s1_illegal", 32'(illegal), 32'd0);
    tick();
    chk("r_s6_state", 32'(state), 32'd6);
    chk("r_s6_alu", 32'({alusrca, alusrcb, aluop}), 32'b1_00_111);
    chk("r_s6_done", 32'(instr_done), 32'd0);
    tick();
    chk("r_s8_state", 32'(state), 32'd8);
    chk("r_s8_wb", 32'({regdst, regwrite, instr_done}), 32'b111);
    tick();
    chk("r_end_state", 32'(state), 32'd0);
    chk("r_end_done", 32'(instr_done), 32'd0);

    // lw with two wait-states in MEMRD; Op changes after DECODE are ignored
    Op = 6'b100011;
    tick();
    chk("lw_s1_state", 32'(state), 32'd1);
    tick();
    Op = 6'b000000;
    mem_ready = 1'b0; #1;
    chk("lw_s2_state", 32'(state), 32'd2);
    chk("lw_s2_alu", 32'({alusrca, alusrcb, aluop}), 32'b1_10_001);
    tick();
    chk("lw_s3a_state", 32'(state), 32'd3);
    chk("lw_s3a_rd", 32'({iord, memread}), 32'b11);
    tick();
    chk("lw_s3b_state", 32'(state), 32'd3);
    chk("lw_s3b_rd", 32'({iord, memread}), 32'b11);
    tick();
    mem_ready = 1'b1; #1;
    chk("lw_s3c_state", 32'(state), 32'd3);
    chk("lw_s3c_rd", 32'({iord, memread}), 32'b11);
    tick();
    chk("lw_s4_state", 32'(state), 32'd4);
    chk("lw_s4_wb", 32'({memtoreg, regwrite, instr_done, regdst}), 32'b1110);
    tick();
    chk("lw_end_state", 32'(state), 32'd0);

    // sw, beq, j back-to-back: 4 + 3 + 3 cycles
    Op = 6'b101011;
    tick();
    chk("sw_s1_state", 32'(state), 32'd1);
    tick();
    chk("sw_s2_state", 32'(state), 32'd2);
    chk("sw_s2_memwrite", 32'(memwrite), 32'd0);
    tick();
    Op = 6'b000100; #1;
    chk("sw_s5_state", 32'(state), 32'd5);
    chk("sw_s5_wr", 32'({iord, memwrite, instr_done}), 32'b111);
    tick();
    chk("beq_s0_state", 32'(state), 32'd0);
    chk("beq_s0_memwrite", 32'(memwrite), 32'd0);
    tick();
    chk("beq_s1_state", 32'(state), 32'd1);
    tick();
    Op = 6'b000010; #1;
    chk("beq_s9_state", 32'(state), 32'd9);
    chk("beq_s9_ctl", 32'({pcwritecond, pcsrc, alusrca, alusrcb, aluop, instr_done, pcwrite}),
        32'b1_01_1_00_000_1_0);
    tick();
    chk("j_s0_state", 32'(state), 32'd0);
    tick();
    chk("j_s1_state", 32'(state), 32'd1);
    tick();
    chk("j_s10_state", 32'(state), 32'd10);
    chk("j_s10_ctl", 32'({pcwrite, pcsrc, instr_done, pcwritecond}), 32'b1_10_1_0);
    tick();
    chk("j_end_state", 32'(state), 32'd0);

    // Illegal opcode: 2 cycles, no write strobes
    Op = 6'b111111;
    tick();
    chk("ill_s1_state", 32'(state), 32'd1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_no_wr", 32'({regwrite, memwrite, pcwrite, instr_done, pcwritecond, irwrite}), 32'd0);
    tick();
    chk("ill_end_state", 32'(state), 32'd0);
    chk("ill_end_pulse", 32'(illegal), 32'd0);

    // FETCH stall for 3 cycles, compared against the no-wait instance
    rst_n = 1'b0;
    Op    = 6'b000000;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b0; #1;
    chk("fst_c1_pc_ir", 32'({pcwrite, irwrite, memread}), 32'b001);
    chk("fst_nw_pc_ir", 32'({n_pcwrite, n_irwrite}), 32'b11);
    chk("fst_nw_aluop", 32'(n_aluop), 32'd1);
    tick();
    chk("fst_c2_state", 32'(state), 32'd0);
    chk("fst_c2_pc_ir", 32'({pcwrite, irwrite}), 32'b00);
    chk("fst_nw_state", 32'(n_state), 32'd1);
    tick();
    chk("fst_c3_state", 32'(state), 32'd0);
    chk("fst_c3_pc_ir", 32'({pcwrite, irwrite}), 32'b00);
    chk("fst_nw_s6_aluop", 32'({n_state, n_aluop}), 32'h67);
    tick();
    mem_ready = 1'b1; #1;
    chk("fst_c4_pc_ir", 32'({pcwrite, irwrite}), 32'b11);
    tick();
    chk("fst_s1_state", 32'(state), 32'd1);

    // Reset during a stalled MEMWR
    Op = 6'b101011;
    tick();
    mem_ready = 1'b0; #1;
    chk("rmw_s2_state", 32'(state), 32'd2);
    tick();
    chk("rmw_s5_state", 32'(state), 32'd5);
    chk("rmw_s5_wr", 32'({iord, memwrite, instr_done}), 32'b100);
    rst_n = 1'b0; #1;
    chk("rmw_rst_ctl", 32'(ctl), 32'd0);
    tick();
    chk("rmw_rst2_ctl", 32'(ctl), 32'd0);
    rst_n = 1'b1; #1;
    chk("rmw_rel_state", 32'(state), 32'd0);
    chk("rmw_rel_memwrite", 32'(memwrite), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
